// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multicycle controller of the 16-bit datapath:
//   - opcode values as they appear in IR[15:12]
//   - controller state encoding
//   - mux-select / ALU-op codes driven onto the datapath
//   - packed control-word struct that bundles every controller output
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Opcodes; 8..15 are undefined and flagged as illegal in DECODE.
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BNE   = 4'd5;
    localparam logic [3:0] OP_J     = 4'd6;
    localparam logic [3:0] OP_JAL   = 4'd7;

    // Controller states. Encodings 13..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_I_WB     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_LD_WB    = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand A / B selects
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REGA    = 1'b1;
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_ONE     = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNK   = 2'b10;

    // Register-file destination and write-data selects
    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_RD    = 2'b01;
    localparam logic [1:0] REGDST_R7    = 2'b10;
    localparam logic [1:0] M2R_ALUOUT   = 2'b00;
    localparam logic [1:0] M2R_MDR      = 2'b01;
    localparam logic [1:0] M2R_PC       = 2'b10;

    // Complete control word presented to the datapath each cycle.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal_op;
    } ctl_t;

    localparam ctl_t CTL_IDLE = ctl_t'(18'd0);

    // Dispatch target out of DECODE for a given opcode (illegal ops go back to FETCH).
    function automatic state_t decode_target(input logic [3:0] opc);
        state_t nxt;
        case (opc)
            OP_RTYPE:      nxt = ST_EXEC_R;
            OP_ADDI:       nxt = ST_EXEC_I;
            OP_LW, OP_SW:  nxt = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: nxt = ST_BRANCH;
            OP_J, OP_JAL:  nxt = ST_JUMP;
            default:       nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Moore-style controller sequencing a 16-bit multicycle datapath (PC, memory,
// IR, register file, ALU). Decodes op from the IR, stalls on the single shared
// memory port and counts retired instructions.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   async active-low reset (aborts any instruction in flight)
//   op           in   opcode from IR[15:12]
//   funk         in   R-type function field from IR[2:0] (consumed by the ALU
//                     control when alu_op selects it; not needed for sequencing)
//   alu_zero     in   ALU zero flag, meaningful in BRANCH
//   mem_ready    in   memory completes the outstanding access this cycle
//   mem_read/mem_write/i_or_d           memory port request and address select
//   ir_write/pc_en/pc_source            IR and PC update controls
//   alu_src_a/alu_src_b/alu_op          ALU operand and operation selects
//   reg_write/reg_dst/mem_to_reg        register-file write controls
//   illegal_op   out  one-cycle pulse in DECODE on an undefined opcode
//   instr_count  out  retired-instruction count, wraps
//
// Outputs are decoded from the state register only, except ir_write/pc_en in
// FETCH (gated by mem_ready) and pc_en in BRANCH (from alu_zero), which must
// react in the same cycle.
// -----------------------------------------------------------------------------
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int FUNK_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [OP_W-1:0]   op,
    input  logic [FUNK_W-1:0] funk,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic              i_or_d,
    output logic              ir_write,
    output logic              pc_en,
    output logic [1:0]        pc_source,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              reg_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  instr_count
);

    state_t            state_r;
    state_t            state_next_s;
    logic              retire_s;
    logic [CNT_W-1:0]  instr_count_r;
    ctl_t              ctl_s;
    logic [3:0]        opc_s;
    logic              is_bne_s;
    logic              is_sw_s;
    logic              is_jal_s;
    logic              op_illegal_s;
    logic              unused_funk_s;

    // The function field only steers the ALU control, not the sequencing.
    assign unused_funk_s = ^funk;

    assign opc_s        = 4'(op);
    assign is_bne_s     = (opc_s == OP_BNE);
    assign is_sw_s      = (opc_s == OP_SW);
    assign is_jal_s     = (opc_s == OP_JAL);
    assign op_illegal_s = (opc_s > OP_JAL);

    // Next-state selection and retire detection (edge leaving a final state).
    always_comb begin
        state_next_s = ST_FETCH;
        retire_s     = 1'b0;
        case (state_r)
            ST_RESET:    state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE:   state_next_s = decode_target(opc_s);
            ST_EXEC_R:   state_next_s = ST_R_WB;
            ST_EXEC_I:   state_next_s = ST_I_WB;
            ST_MEM_ADDR: begin
                if (is_sw_s) begin
                    state_next_s = ST_MEM_WR;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_next_s = ST_LD_WB;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_next_s = ST_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_R_WB, ST_I_WB, ST_LD_WB, ST_BRANCH, ST_JUMP: begin
                state_next_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            default:     state_next_s = ST_FETCH;
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_RESET;
            instr_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (retire_s) begin
                instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                instr_count_r <= instr_count_r;
            end
        end
    end

    // Control-word decode from the current state.
    always_comb begin
        ctl_s = CTL_IDLE;
        case (state_r)
            ST_RESET: ctl_s = CTL_IDLE;
            ST_FETCH: begin
                ctl_s.mem_read  = 1'b1;
                ctl_s.i_or_d    = 1'b0;
                ctl_s.alu_src_a = SRCA_PC;
                ctl_s.alu_src_b = SRCB_ONE;
                ctl_s.alu_op    = ALUOP_ADD;
                ctl_s.pc_source = PCSRC_ALU;
                // IR capture and PC+1 only on the cycle the fetch completes.
                ctl_s.ir_write  = mem_ready;
                ctl_s.pc_en     = mem_ready;
            end
            ST_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctl_s.alu_src_a  = SRCA_PC;
                ctl_s.alu_src_b  = SRCB_IMM;
                ctl_s.alu_op     = ALUOP_ADD;
                ctl_s.illegal_op = op_illegal_s;
            end
            ST_EXEC_R: begin
                ctl_s.alu_src_a = SRCA_REGA;
                ctl_s.alu_src_b = SRCB_REGB;
                ctl_s.alu_op    = ALUOP_FUNK;
            end
            ST_R_WB: begin
                ctl_s.reg_write  = 1'b1;
                ctl_s.reg_dst    = REGDST_RD;
                ctl_s.mem_to_reg = M2R_ALUOUT;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctl_s.alu_src_a = SRCA_REGA;
                ctl_s.alu_src_b = SRCB_IMM;
                ctl_s.alu_op    = ALUOP_ADD;
            end
            ST_I_WB: begin
                ctl_s.reg_write  = 1'b1;
                ctl_s.reg_dst    = REGDST_RT;
                ctl_s.mem_to_reg = M2R_ALUOUT;
            end
            ST_MEM_RD: begin
                ctl_s.mem_read = 1'b1;
                ctl_s.i_or_d   = 1'b1;
            end
            ST_LD_WB: begin
                ctl_s.reg_write  = 1'b1;
                ctl_s.reg_dst    = REGDST_RT;
                ctl_s.mem_to_reg = M2R_MDR;
            end
            ST_MEM_WR: begin
                ctl_s.mem_write = 1'b1;
                ctl_s.i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                ctl_s.alu_src_a = SRCA_REGA;
                ctl_s.alu_src_b = SRCB_REGB;
                ctl_s.alu_op    = ALUOP_SUB;
                ctl_s.pc_source = PCSRC_ALUOUT;
                // beq takes on zero, bne on non-zero.
                ctl_s.pc_en     = alu_zero ^ is_bne_s;
            end
            ST_JUMP: begin
                ctl_s.pc_source = PCSRC_JUMP;
                ctl_s.pc_en     = 1'b1;
                if (is_jal_s) begin
                    // PC already holds the return address (incremented in FETCH).
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.reg_dst    = REGDST_R7;
                    ctl_s.mem_to_reg = M2R_PC;
                end else begin
                    ctl_s.reg_write  = 1'b0;
                end
            end
            default: ctl_s = CTL_IDLE;
        endcase
    end

    assign mem_read    = ctl_s.mem_read;
    assign mem_write   = ctl_s.mem_write;
    assign i_or_d      = ctl_s.i_or_d;
    assign ir_write    = ctl_s.ir_write;
    assign pc_en       = ctl_s.pc_en;
    assign pc_source   = ctl_s.pc_source;
    assign alu_src_a   = ctl_s.alu_src_a;
    assign alu_src_b   = ctl_s.alu_src_b;
    assign alu_op      = ctl_s.alu_op;
    assign reg_write   = ctl_s.reg_write;
    assign reg_dst     = ctl_s.reg_dst;
    assign mem_to_reg  = ctl_s.mem_to_reg;
    assign illegal_op  = ctl_s.illegal_op;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Scoreboard bench. An instruction-level reference model expands each issued
// instruction into the sequence of per-cycle control words it must produce,
// pushing each expectation as its inputs are driven; a monitor on the falling
// edge pops and compares. A second instance with a 4-bit counter checks wrap.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        ctl_t        exp;
        logic [15:0] cnt;
        string       tag;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [2:0]  funk = 3'd0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_read, mem_write, i_or_d, ir_write, pc_en, alu_src_a, reg_write, illegal_op;
    logic [1:0]  pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic [15:0] instr_count;

    logic        d4_mem_read, d4_mem_write, d4_i_or_d, d4_ir_write, d4_pc_en, d4_alu_src_a, d4_reg_write, d4_illegal_op;
    logic [1:0]  d4_pc_source, d4_alu_src_b, d4_alu_op, d4_reg_dst, d4_mem_to_reg;
    logic [3:0]  d4_instr_count;

    ctl_t act_ctl, act4_ctl;
    sb_t  sb[$];
    int   tests = 0;
    int   fails = 0;
    int   retired = 0;

    always #5 clock = ~clock;

    multicycle_control_fsm dut (
        .clock(clock), .reset_n(reset_n), .op(op), .funk(funk),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    multicycle_control_fsm #(.CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .op(op), .funk(funk),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_read(d4_mem_read), .mem_write(d4_mem_write), .i_or_d(d4_i_or_d),
        .ir_write(d4_ir_write), .pc_en(d4_pc_en), .pc_source(d4_pc_source),
        .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op),
        .reg_write(d4_reg_write), .reg_dst(d4_reg_dst), .mem_to_reg(d4_mem_to_reg),
        .illegal_op(d4_illegal_op), .instr_count(d4_instr_count)
    );

    assign act_ctl  = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                       alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op};
    assign act4_ctl = {d4_mem_read, d4_mem_write, d4_i_or_d, d4_ir_write, d4_pc_en, d4_pc_source,
                       d4_alu_src_a, d4_alu_src_b, d4_alu_op, d4_reg_write, d4_reg_dst,
                       d4_mem_to_reg, d4_illegal_op};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Monitor: compare the DUT against the oldest expectation each falling edge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            sb_t r;
            r = sb.pop_front();
            chk({"ctl_", r.tag},  32'(act_ctl),        32'(r.exp));
            chk({"ctl4_", r.tag}, 32'(act4_ctl),       32'(r.exp));
            chk({"cnt_", r.tag},  32'(instr_count),    32'(r.cnt));
            chk({"cnt4_", r.tag}, 32'(d4_instr_count), 32'(r.cnt[3:0]));
        end
    end

    // One controller cycle: drive inputs after the edge, record the expectation.
    task automatic step(input string ph, input logic [3:0] opc, input logic rdy,
                        input logic zero, input ctl_t e);
        sb_t r;
        @(posedge clock);
        #1;
        op        = opc;
        funk      = 3'($urandom);
        mem_ready = rdy;
        alu_zero  = zero;
        r.exp = e;
        r.cnt = 16'(retired);
        r.tag = ph;
        sb.push_back(r);
    endtask

    task automatic release_reset();
        sb_t r;
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        mem_ready = rb();
        alu_zero  = rb();
        r.exp = ctl_t'(18'd0);
        r.cnt = 16'(retired);
        r.tag = "RESET";
        sb.push_back(r);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        retired = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ctl", 32'(act_ctl), 32'd0);
        chk("reset_cnt", 32'(instr_count), 32'd0);
        release_reset();
    endtask

    // Reference model: expected cycle-by-cycle control words for one instruction.
    task automatic run_instr(input logic [3:0] opc, input int fw, input int mw,
                             input logic zero, input bit abort_wr);
        ctl_t c;
        for (int i = 0; i < fw; i++) begin
            c = ctl_t'(18'd0); c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            step("FETCH_WAIT", opc, 1'b0, rb(), c);
        end
        c = ctl_t'(18'd0); c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        c.ir_write = 1'b1; c.pc_en = 1'b1;
        step("FETCH", opc, 1'b1, rb(), c);

        c = ctl_t'(18'd0); c.alu_src_b = 2'b10; c.illegal_op = (opc > 4'd7);
        step("DECODE", opc, rb(), rb(), c);
        if (opc > 4'd7) return;

        case (opc)
            4'd0: begin
                c = ctl_t'(18'd0); c.alu_src_a = 1'b1; c.alu_op = 2'b10;
                step("EXEC_R", opc, rb(), rb(), c);
                c = ctl_t'(18'd0); c.reg_write = 1'b1; c.reg_dst = 2'b01;
                step("R_WB", opc, rb(), rb(), c);
                retired++;
            end
            4'd1: begin
                c = ctl_t'(18'd0); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                step("EXEC_I", opc, rb(), rb(), c);
                c = ctl_t'(18'd0); c.reg_write = 1'b1;
                step("I_WB", opc, rb(), rb(), c);
                retired++;
            end
            4'd2, 4'd3: begin
                c = ctl_t'(18'd0); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                step("MEM_ADDR", opc, rb(), rb(), c);
                c = ctl_t'(18'd0); c.i_or_d = 1'b1;
                if (opc == 4'd2) c.mem_read = 1'b1; else c.mem_write = 1'b1;
                if (abort_wr) begin
                    step("MEM_WAIT", opc, 1'b0, rb(), c);
                    return;
                end
                for (int i = 0; i < mw; i++) step("MEM_WAIT", opc, 1'b0, rb(), c);
                step("MEM_DONE", opc, 1'b1, rb(), c);
                if (opc == 4'd2) begin
                    c = ctl_t'(18'd0); c.reg_write = 1'b1; c.mem_to_reg = 2'b01;
                    step("LD_WB", opc, rb(), rb(), c);
                end
                retired++;
            end
            4'd4, 4'd5: begin
                c = ctl_t'(18'd0); c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_source = 2'b01; c.pc_en = zero ^ (opc == 4'd5);
                step("BRANCH", opc, rb(), zero, c);
                retired++;
            end
            default: begin
                c = ctl_t'(18'd0); c.pc_source = 2'b10; c.pc_en = 1'b1;
                if (opc == 4'd7) begin
                    c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                end
                step("JUMP", opc, rb(), rb(), c);
                retired++;
            end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        run_instr(4'd0, 0, 0, 1'b0, 1'b0);   // R-type, immediate fetch
        run_instr(4'd2, 1, 3, 1'b0, 1'b0);   // lw, 3 wait cycles in MEM_RD
        run_instr(4'd4, 0, 0, 1'b1, 1'b0);   // beq taken
        run_instr(4'd4, 0, 0, 1'b0, 1'b0);   // beq not taken
        run_instr(4'd5, 0, 0, 1'b1, 1'b0);   // bne not taken
        run_instr(4'd5, 0, 0, 1'b0, 1'b0);   // bne taken
        run_instr(4'd7, 0, 0, 1'b0, 1'b0);   // jal
        run_instr(4'd6, 2, 0, 1'b0, 1'b0);   // j
        run_instr(4'd12, 0, 0, 1'b0, 1'b0);  // illegal
        run_instr(4'd1, 0, 0, 1'b0, 1'b0);   // addi
        run_instr(4'd3, 0, 2, 1'b0, 1'b0);   // sw

        // Reset while a store is pending: the request must drop immediately.
        run_instr(4'd3, 0, 0, 1'b0, 1'b1);
        #5;
        reset_n = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_ctl", 32'(act_ctl), 32'd0);
        chk("abort_cnt", 32'(instr_count), 32'd0);
        retired = 0;
        repeat (2) @(posedge clock);
        release_reset();

        // Enough 4-bit counter wraps for the small instance.
        for (int i = 0; i < 20; i++) run_instr(4'd1, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            run_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), rb(), 1'b0);
        end

        @(negedge clock);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
